// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and geometry for the instruction fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

   // FILL waits out the memory latency; HIT serves words from the line buffer.
   typedef enum logic [0:0] {
      FILL = 1'b0,
      HIT  = 1'b1
   } fetch_state_t;

   localparam int LINE_BYTES  = 8;
   localparam int INSTR_BYTES = 4;
   localparam int LINE_OFF_W  = 3;
   localparam int LINE_W      = LINE_BYTES * 8;
   localparam int INSTR_W     = INSTR_BYTES * 8;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundle of redirect, memory and decode-side signals of the fetch stage.
// Latency: n/a (wiring only).
// Backpressure: decode stalls delivery through instr_ready.
interface instruction_fetch_unit_if #(
   parameter int ADDR_W = 16
);
   import fetch_pkg::*;

   logic                redirect_valid;
   logic [ADDR_W-1:0]   redirect_pc;
   logic [ADDR_W-1:0]   mem_addr;
   logic [LINE_W-1:0]   mem_line;
   logic                instr_valid;
   logic                instr_ready;
   logic [INSTR_W-1:0]  instr;
   logic [ADDR_W-1:0]   instr_pc;

   // Fetch unit side.
   modport master (
      input  redirect_valid, redirect_pc, mem_line, instr_ready,
      output mem_addr, instr_valid, instr, instr_pc
   );

   // Environment side: execute, instruction memory and decode.
   modport slave (
      output redirect_valid, redirect_pc, mem_line, instr_ready,
      input  mem_addr, instr_valid, instr, instr_pc
   );

endinterface

// File: rtl/fetch_line_buffer.sv
// Single-line buffer: holds one 64-bit memory line, its tag and a valid bit.
// Latency: capture visible next cycle; hit compare and word select are combinational.
// Backpressure: none; capture/invalidate are obeyed every cycle, invalidate wins.
module fetch_line_buffer
   import fetch_pkg::*;
#(
   parameter int TAG_W = 13
) (
   input  logic               clk,
   input  logic               invalidate_i,
   input  logic               capture_i,
   input  logic [LINE_W-1:0]  line_i,
   input  logic [TAG_W-1:0]   cap_tag_i,
   input  logic [TAG_W-1:0]   lookup_tag_i,
   input  logic               word_sel_i,
   output logic               hit_o,
   output logic [INSTR_W-1:0] word_o
);

   logic [LINE_W-1:0] line_buf_q;
   logic [TAG_W-1:0]  line_tag_q;
   logic              line_valid_q;

   // Valid bit: invalidate (driven by reset) beats capture.
   always_ff @(posedge clk) begin
      if (invalidate_i) begin
         line_valid_q <= 1'b0;
      end else if (capture_i) begin
         line_valid_q <= 1'b1;
      end
   end

   // Line data and tag only change on capture; contents are meaningless while invalid.
   always_ff @(posedge clk) begin
      if (capture_i) begin
         line_buf_q <= line_i;
         line_tag_q <= cap_tag_i;
      end
   end

   assign hit_o  = line_valid_q && (lookup_tag_i == line_tag_q);
   // Byte 0 of the line sits in the top bits, so the first word is the upper half.
   assign word_o = word_sel_i ? line_buf_q[INSTR_W-1:0] : line_buf_q[LINE_W-1:INSTR_W];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, fills one line from memory, then streams its two words to decode.
// Latency: MEM_LATENCY cycles per line fill; redirect to the buffered line is served next cycle.
// Backpressure: instr_ready low freezes PC and outputs; redirect always overrides.
module instruction_fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W      = 16,
   parameter int                MEM_LATENCY = 6,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   instruction_fetch_unit_if.master  fif
);

   localparam int                TAG_W        = ADDR_W - LINE_OFF_W;
   localparam int                CNT_W        = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0]  LAST_CNT     = CNT_W'(MEM_LATENCY - 1);
   localparam logic [ADDR_W-1:0] RESET_PC_ALN = {RESET_PC[ADDR_W-1:2], 2'b00};

   fetch_state_t        state_q;
   logic [ADDR_W-1:0]   pc_q;
   logic [CNT_W-1:0]    wait_cnt_q;
   logic                instr_valid_q;

   logic [ADDR_W-1:0]   redirect_pc_aln;
   logic [ADDR_W-1:0]   pc_inc;
   logic                fill_done;
   logic                capture;
   logic                line_hit;
   logic [INSTR_W-1:0]  buf_word;
   logic                unused_redirect_lsbs;

   assign redirect_pc_aln      = {fif.redirect_pc[ADDR_W-1:2], 2'b00};
   // The byte offset within a word is ignored; pc stays word aligned.
   assign unused_redirect_lsbs = ^fif.redirect_pc[1:0];
   assign pc_inc               = pc_q + ADDR_W'(INSTR_BYTES);
   assign fill_done            = (state_q == FILL) && (wait_cnt_q == LAST_CNT);
   // A redirect or reset in the final wait cycle abandons the line being filled.
   assign capture              = fill_done && !fif.redirect_valid && !reset;

   fetch_line_buffer #(
      .TAG_W (TAG_W)
   ) u_line_buffer (
      .clk          (clk),
      .invalidate_i (reset),
      .capture_i    (capture),
      .line_i       (fif.mem_line),
      .cap_tag_i    (pc_q[ADDR_W-1:LINE_OFF_W]),
      .lookup_tag_i (fif.redirect_pc[ADDR_W-1:LINE_OFF_W]),
      .word_sel_i   (pc_q[2]),
      .hit_o        (line_hit),
      .word_o       (buf_word)
   );

   // Fetch FSM: reset, then redirect, then fill countdown / handshake-driven PC advance.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= FILL;
         pc_q          <= RESET_PC_ALN;
         wait_cnt_q    <= '0;
         instr_valid_q <= 1'b0;
      end else if (fif.redirect_valid) begin
         pc_q       <= redirect_pc_aln;
         wait_cnt_q <= '0;
         if (line_hit) begin
            state_q       <= HIT;
            instr_valid_q <= 1'b1;
         end else begin
            state_q       <= FILL;
            instr_valid_q <= 1'b0;
         end
      end else begin
         case (state_q)
            FILL: begin
               if (fill_done) begin
                  wait_cnt_q    <= '0;
                  state_q       <= HIT;
                  instr_valid_q <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + CNT_W'(1);
               end
            end
            HIT: begin
               if (fif.instr_ready) begin
                  pc_q <= pc_inc;
                  // Leaving the last word of the line means a new fill.
                  if (pc_q[2]) begin
                     state_q       <= FILL;
                     instr_valid_q <= 1'b0;
                  end
               end
            end
            default: begin
               state_q       <= FILL;
               instr_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign fif.mem_addr    = {pc_q[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
   assign fif.instr_valid = instr_valid_q;
   assign fif.instr       = instr_valid_q ? buf_word : '0;
   assign fif.instr_pc    = pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a latency-aware memory model.
// Latency: memory returns garbage until an address has been held MEM_LATENCY cycles.
// Backpressure: instr_ready and redirect are driven from directed sequences.
module tb_instruction_fetch_unit;

   localparam int LAT = 6;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   int   cyc;

   instruction_fetch_unit_if #(.ADDR_W(16)) ifc ();

   instruction_fetch_unit #(
      .ADDR_W      (16),
      .MEM_LATENCY (LAT),
      .RESET_PC    (16'h0000)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .fif   (ifc.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word stored at a byte address; line 0 holds the two reference words.
   function automatic logic [31:0] word_at(input logic [15:0] a);
      if (a == 16'h0000) return 32'h11111111;
      if (a == 16'h0004) return 32'h22222222;
      return {16'hC0DE, a};
   endfunction

   function automatic logic [63:0] line_at(input logic [15:0] a);
      logic [15:0] base;
      base = {a[15:3], 3'b000};
      return {word_at(base), word_at(base + 16'd4)};
   endfunction

   // Memory: data only becomes valid after the address has been held LAT cycles.
   logic [15:0] prev_addr;
   int          held;
   always @(posedge clk) begin
      #1;
      if (ifc.mem_addr !== prev_addr) held = 1;
      else held = held + 1;
      prev_addr = ifc.mem_addr;
      ifc.mem_line = (held >= LAT) ? line_at(ifc.mem_addr) : 64'hBAD0_BAD0_BAD0_BAD0;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   // Advance one clock; redirect is a single-cycle pulse.
   task automatic step();
      @(posedge clk);
      #2;
      cyc++;
      ifc.redirect_valid = 1'b0;
   endtask

   task automatic redirect(input logic [15:0] target);
      ifc.redirect_valid = 1'b1;
      ifc.redirect_pc    = target;
   endtask

   task automatic exp_bubble(input string tag, input logic [15:0] maddr);
      chk({tag, "_vld"},   64'(ifc.instr_valid), 64'd0);
      chk({tag, "_instr"}, 64'(ifc.instr),       64'd0);
      chk({tag, "_maddr"}, 64'(ifc.mem_addr),    64'(maddr));
   endtask

   task automatic exp_instr(input string tag, input logic [15:0] pc);
      chk({tag, "_vld"},   64'(ifc.instr_valid), 64'd1);
      chk({tag, "_pc"},    64'(ifc.instr_pc),    64'(pc));
      chk({tag, "_instr"}, 64'(ifc.instr),       64'(word_at(pc)));
   endtask

   task automatic run_bubbles(input int n, input string tag, input logic [15:0] maddr);
      for (int i = 0; i < n; i++) begin
         step();
         exp_bubble(tag, maddr);
      end
   endtask

   initial begin
      checks             = 0;
      failures           = 0;
      cyc                = 0;
      reset              = 1'b1;
      ifc.redirect_valid = 1'b0;
      ifc.redirect_pc    = 16'h0000;
      ifc.instr_ready    = 1'b1;

      // Reset at edge 0; cycle 1 shows reset outputs.
      step();
      reset = 1'b0;
      exp_bubble("rst", 16'h0000);
      chk("rst_pc", 64'(ifc.instr_pc), 64'd0);
      run_bubbles(5, "fill0", 16'h0000);             // cycles 2..6
      step(); exp_instr("l0w0", 16'h0000);            // cycle 7
      step(); exp_instr("l0w1", 16'h0004);            // cycle 8
      run_bubbles(LAT, "cross", 16'h0008);            // cycles 9..14
      step(); exp_instr("l8w0", 16'h0008);            // cycle 15

      // Decode stall: everything holds, no new fetch.
      ifc.instr_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         exp_instr("stall", 16'h0008);
         chk("stall_maddr", 64'(ifc.mem_addr), 64'h0008);
      end
      ifc.instr_ready = 1'b1;
      step(); exp_instr("l8w1", 16'h000C);            // cycle 19

      // Redirect hit in the buffered line (offset bits ignored).
      ifc.instr_ready = 1'b0;
      redirect(16'h000A);
      step(); exp_instr("rd_hit8", 16'h0008);

      // Redirect to a different line: full refill.
      redirect(16'h0004);
      run_bubbles(LAT, "rd_miss0", 16'h0000);
      step(); exp_instr("rd_fill0", 16'h0004);

      // Redirects within line 0: no bubble.
      redirect(16'h0000);
      step(); exp_instr("rd_hit0", 16'h0000);
      redirect(16'h0004);
      step(); exp_instr("rd_hit4", 16'h0004);

      // Redirect miss to 0x40.
      redirect(16'h0040);
      run_bubbles(LAT, "rd_miss40", 16'h0040);
      step(); exp_instr("l40", 16'h0040);

      // Redirect together with a handshake; then redirect in FILL cycle 4 to the same line.
      ifc.instr_ready = 1'b1;
      redirect(16'h0100);
      run_bubbles(4, "rd_hs", 16'h0100);              // FILL cycles 1..4
      redirect(16'h0106);
      run_bubbles(LAT, "rd_restart", 16'h0100);
      step(); exp_instr("restart", 16'h0104);

      // Redirect to the top word; PC wraps and refills line 0.
      redirect(16'hFFFE);
      run_bubbles(LAT, "wrap_fill", 16'hFFF8);
      step(); exp_instr("top", 16'hFFFC);
      run_bubbles(LAT, "wrap0", 16'h0000);
      step(); exp_instr("wrap_l0", 16'h0000);

      // Reset during HIT: stale line 0 must not satisfy a redirect.
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp_bubble("rst_hit", 16'h0000);
      chk("rst_hit_pc", 64'(ifc.instr_pc), 64'd0);
      redirect(16'h0004);
      run_bubbles(LAT, "rst_stale", 16'h0000);
      step(); exp_instr("rst_refill", 16'h0004);

      // Reset during FILL of line 8.
      run_bubbles(3, "pre_rst", 16'h0008);
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp_bubble("rst_fill", 16'h0000);
      chk("rst_fill_pc", 64'(ifc.instr_pc), 64'd0);
      redirect(16'h0000);
      run_bubbles(LAT, "rst_fill_stale", 16'h0000);
      step(); exp_instr("rst_fill_w0", 16'h0000);
      step(); exp_instr("rst_fill_w1", 16'h0004);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage directly upstream of `instruction_memory`: owns the program counter, drives the 16-bit byte address into the memory, waits out the memory's fixed access latency, and captures the 64-bit line. It then delivers the line's two 32-bit instructions, one per cycle, to decode over a valid/ready handshake. Branch and jump redirects from execute enter here; a redirect that hits the buffered line skips the memory wait.

## Interface
- `ADDR_W`, 16, byte-address width; matches the memory address port.
- `MEM_LATENCY`, 6, cycles `mem_addr` must be held stable before `mem_line` is valid; must be ≥ 1.
- `RESET_PC`, 16'h0000, PC loaded on reset; bits [1:0] ignored.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `redirect_valid`  in  1  load a new PC this cycle.
- `redirect_pc`  in  ADDR_W  redirect target; bits [1:0] ignored.
- `mem_addr`  out  ADDR_W  line address to memory, always `{pc[15:3],3'b000}`.
- `mem_line`  in  64  line from memory; byte at offset 0 sits in bits [63:56].
- `instr_valid`  out  1  `instr`/`instr_pc` hold a valid instruction.
- `instr_ready`  in  1  decode accepts this cycle.
- `instr`  out  32  instruction word.
- `instr_pc`  out  ADDR_W  byte address of `instr`, bits [1:0] = 0.

## Operation
- State: `pc` (bits [1:0] always 0), `line_buf[63:0]`, `line_tag[12:0]`, `line_valid`, `wait_cnt`, FSM {FILL, HIT}.
- Reset: `pc`=`{RESET_PC[15:2],2'b00}`, `line_valid`=0, `wait_cnt`=0, FSM=FILL. Outputs: `instr_valid`=0, `instr`=0, `instr_pc`=`pc`, `mem_addr`=`{RESET_PC[15:3],000}`.
- FILL:
  - `instr_valid`=0 and `instr`=0.
  - `wait_cnt` increments each cycle.
  - When `wait_cnt`==MEM_LATENCY-1: capture `mem_line` into `line_buf`, set `line_tag`=`pc[15:3]` and `line_valid`=1, clear `wait_cnt`, go to HIT.
  - `mem_line` is X outside this window and must never be sampled earlier.
- HIT:
  - `instr_valid`=1.
  - `instr` = `pc[2]` ? `line_buf[31:0]` : `line_buf[63:32]` (combinational from registers).
  - Handshake fires when `instr_valid & instr_ready`; then `pc` ← `pc`+4 (16-bit, wraps 0xFFFC→0x0000).
  - If the old `pc[2]`=1 (last word of the line), go to FILL; otherwise stay in HIT.
  - No handshake: everything holds.
- Redirect (any state, highest priority):
  - `pc` ← `{redirect_pc[15:2],2'b00}` and `wait_cnt` ← 0.
  - If `line_valid` and `redirect_pc[15:3]`==`line_tag`, go to HIT; else go to FILL.
  - A handshake in the same cycle still counts as accepted by decode, but the next PC comes from the redirect.
  - A redirect during FILL always restarts the wait, even to the same line.
- `reset` overrides redirect and handshake.

## Timing
- Reset sampled at edge 0, deasserted after it: FILL occupies cycles 1..MEM_LATENCY, capture at the end of cycle MEM_LATENCY, first `instr_valid` in cycle MEM_LATENCY+1.
- Within a line: one instruction per cycle while `instr_ready`=1.
- Line crossing: MEM_LATENCY bubble cycles (`instr_valid`=0).
- Redirect hit: `instr_valid` in the very next cycle with the new `instr_pc`.
- Redirect miss: MEM_LATENCY bubble cycles.
- `mem_addr` changes only on a PC update and is stable throughout FILL.

## Structure
- Package `fetch_pkg`: FSM enum `fetch_state_t` {FILL, HIT}; `LINE_BYTES`=8; `INSTR_BYTES`=4; `LINE_OFF_W`=3.
- One sub-module, `fetch_line_buffer`:
  - holds `line_buf`, `line_tag` and `line_valid`;
  - takes capture/invalidate inputs;
  - outputs the tag-hit compare and the word select.
- The top level holds the FSM, `pc` and `wait_cnt`.

## Test plan
- Reset, RESET_PC=0, MEM_LATENCY=6, memory line 0 = 64'h11111111_22222222, `instr_ready`=1 → `instr_valid` first high in cycle 7 with `instr`=32'h11111111 / `instr_pc`=0, then 32'h22222222 / 4, then 6 bubble cycles, then line 8.
- `instr_ready`=0 for 3 cycles in HIT → `instr`, `instr_pc` and `instr_valid` held; no PC advance and no extra fetch.
- Redirect to 0x0004 while in HIT on line 0 → next cycle `instr_pc`=4 with no bubble; redirect to 0x0040 → 6 bubbles, `mem_addr`=0x0040.
- Redirect in FILL cycle 4, and simultaneous redirect + handshake → `wait_cnt` restarts; full 6-cycle wait; the redirect target is the next `instr_pc`.
- Redirect to 0xFFFC → after delivering it, `pc` wraps to 0x0000 and refills line 0.
- `reset` asserted mid-FILL and mid-HIT → next cycle matches the reset values; the stale line is not reused (`line_valid`=0).
